// File: rtl/tach_pkg.sv
// ---------------------------------------------------------------------------
// tach_pkg
// Shared definitions for the tachometer scan controller.
//   tach_state_e   : scan FSM state encoding
//   SETTLE_TICKS   : tach ticks spent settling before each measurement
//   PRESCALE_MAX   : largest usable tach_prescale exponent
//   prescale_mask  : low-bit mask selecting the prescaler tick phase
// ---------------------------------------------------------------------------
package tach_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_STORE   = 3'd3,
        ST_NEXT    = 3'd4
    } tach_state_e;

    localparam int SETTLE_TICKS = 4;
    localparam int PRESCALE_MAX = 11;

    // Exponents above PRESCALE_MAX clamp so the 12-bit counter always wraps
    // on a whole number of tick periods.
    function automatic logic [11:0] prescale_mask(input logic [3:0] prescale);
        logic [3:0] p;
        p = (prescale > 4'(PRESCALE_MAX)) ? 4'(PRESCALE_MAX) : prescale;
        return (12'd1 << p) - 12'd1;
    endfunction

endpackage

// File: rtl/tach_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// tach_scan_ctrl_if
// Link between the scan controller and the shared tach measurement engine.
//   eng_tachin       : muxed tach input to the engine
//   tach_cnt_clk     : one-PCLK prescaled tick to the engine
//   eng_status_clear : engine status_clear
//   eng_update       : engine update_status
//   eng_dur          : engine TACHPULSEDUR
// master = controller side, slave = engine side.
// ---------------------------------------------------------------------------
interface tach_scan_ctrl_if;

    logic        eng_tachin;
    logic        tach_cnt_clk;
    logic        eng_status_clear;
    logic        eng_update;
    logic [15:0] eng_dur;

    modport master (
        output eng_tachin,
        output tach_cnt_clk,
        output eng_status_clear,
        input  eng_update,
        input  eng_dur
    );

    modport slave (
        input  eng_tachin,
        input  tach_cnt_clk,
        input  eng_status_clear,
        output eng_update,
        output eng_dur
    );

endinterface

// File: rtl/tach_prescaler.sv
// ---------------------------------------------------------------------------
// tach_prescaler
// Free-running 12-bit counter producing a registered one-PCLK tick every
// 2^tach_prescale PCLKs (exponent clamped to PRESCALE_MAX).
//   PCLK, PRESETN  : clock, async active-low reset
//   tach_prescale  : tick period exponent
//   tick           : one-PCLK tick pulse
// ---------------------------------------------------------------------------
module tach_prescaler
    import tach_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic [3:0] tach_prescale,
    output logic       tick
);

    logic [11:0] cnt;
    logic [11:0] mask;

    assign mask = prescale_mask(tach_prescale);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + 12'd1;
            tick <= ((cnt & mask) == mask);
        end
    end

endmodule

// File: rtl/tach_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tach_scan_ctrl
// Round-robin scan controller sharing one tach measurement engine across
// TACH_NUM fan tach inputs. Steers one input at a time to the engine,
// settles, waits for the engine result, stores it per channel and raises
// sticky status bits and an interrupt.
//
// Optional build macro: TACH_TIMEOUT_EN -- per-channel measurement timeout
// after TIMEOUT_TICKS ticks; without it MEASURE waits indefinitely and
// tach_timeout is tied to 0.
//
// Ports:
//   PCLK, PRESETN   : clock, async active-low reset
//   TACHIN          : raw tach inputs
//   scan_en         : scan enable
//   tach_prescale   : tick period exponent
//   irq_mask        : per-channel interrupt enable
//   status_wr       : write-1-clear strobe for status/timeout
//   status_wdata    : bits to clear
//   rd_ch           : channel index for rd_dur
//   eng             : engine link (master modport)
//   cur_ch          : channel being measured
//   tach_status     : sticky measurement-done bits
//   tach_timeout    : sticky timeout bits
//   rd_dur          : stored duration of rd_ch (0 if out of range)
//   tach_irq        : registered |(tach_status & irq_mask)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | scan disabled, waiting for scan_en
// SETTLE  | count SETTLE_TICKS ticks to flush engine sync / stale edges
// MEASURE | engine status_clear held, wait for tick with eng_update
// STORE   | write eng_dur to dur[cur_ch], set tach_status[cur_ch]
// NEXT    | advance cur_ch (wrapping), back to SETTLE
// ---------------------------------------------------------------------------
module tach_scan_ctrl
    import tach_pkg::*;
#(
    parameter int TACH_NUM      = 4,
    parameter int TIMEOUT_TICKS = 131071
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic [TACH_NUM-1:0] TACHIN,
    input  logic                scan_en,
    input  logic [3:0]          tach_prescale,
    input  logic [TACH_NUM-1:0] irq_mask,
    input  logic                status_wr,
    input  logic [TACH_NUM-1:0] status_wdata,
    input  logic [3:0]          rd_ch,
    tach_scan_ctrl_if.master    eng,
    output logic [3:0]          cur_ch,
    output logic [TACH_NUM-1:0] tach_status,
    output logic [TACH_NUM-1:0] tach_timeout,
    output logic [15:0]         rd_dur,
    output logic                tach_irq
);

    localparam int SW = $clog2(SETTLE_TICKS);

    if (TACH_NUM < 1 || TACH_NUM > 16 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 131071)
    begin : g_param_check
        $error("tach_scan_ctrl: TACH_NUM or TIMEOUT_TICKS out of range");
    end

    tach_state_e          state, state_nxt;
    logic                 tick;
    logic [SW-1:0]        settle_cnt;
    logic                 settle_done;
    logic                 meas_done;
    logic                 meas_timeout;
    logic                 store_en;
    logic                 timeout_en;
    logic                 advance;
    logic [TACH_NUM-1:0]  ch_onehot;
    logic [TACH_NUM-1:0]  clr_bits;
    logic [15:0]          dur [TACH_NUM];

    tach_prescaler u_prescaler (
        .PCLK          (PCLK),
        .PRESETN       (PRESETN),
        .tach_prescale (tach_prescale),
        .tick          (tick)
    );

    assign eng.tach_cnt_clk = tick;

    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < TACH_NUM; i++) begin
            ch_onehot[i] = (cur_ch == 4'(i));
        end
    end

    assign settle_done = tick && (settle_cnt == '0);
    assign meas_done   = tick && eng.eng_update;
    assign clr_bits    = status_wr ? status_wdata : '0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (!scan_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_SETTLE;
                ST_SETTLE:  if (settle_done) state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    if (meas_done)         state_nxt = ST_STORE;
                    else if (meas_timeout) state_nxt = ST_NEXT;
                end
                ST_STORE:   state_nxt = ST_NEXT;
                ST_NEXT:    state_nxt = ST_SETTLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Side effects are gated by scan_en so a disable in any state discards
    // the pending work and leaves cur_ch where it was.
    always_comb begin
        eng.eng_status_clear = 1'b0;
        store_en             = 1'b0;
        timeout_en           = 1'b0;
        advance              = 1'b0;
        case (state)
            ST_MEASURE: begin
                eng.eng_status_clear = 1'b1;
                timeout_en           = scan_en && meas_timeout;
            end
            ST_STORE: store_en = scan_en;
            ST_NEXT:  advance  = scan_en;
            default: ;
        endcase
    end

    // Settle down-counter, reloaded whenever not settling.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            settle_cnt <= SW'(SETTLE_TICKS - 1);
        else if (state != ST_SETTLE)
            settle_cnt <= SW'(SETTLE_TICKS - 1);
        else if (tick && settle_cnt != '0)
            settle_cnt <= settle_cnt - SW'(1);
    end

`ifdef TACH_TIMEOUT_EN
    localparam logic [16:0] TO_LOAD = 17'(TIMEOUT_TICKS - 1);

    logic [16:0]         to_cnt;
    logic [TACH_NUM-1:0] set_timeout;

    // An update on the terminal tick takes precedence over the timeout.
    assign meas_timeout = tick && (to_cnt == '0) && !eng.eng_update;
    assign set_timeout  = timeout_en ? ch_onehot : '0;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            to_cnt <= TO_LOAD;
        else if (state != ST_MEASURE)
            to_cnt <= TO_LOAD;
        else if (tick && to_cnt != '0)
            to_cnt <= to_cnt - 17'd1;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) tach_timeout <= '0;
        else          tach_timeout <= (tach_timeout & ~clr_bits) | set_timeout;
    end
`else
    assign meas_timeout = 1'b0;
    assign tach_timeout = '0;
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            cur_ch <= 4'd0;
        else if (advance)
            cur_ch <= (cur_ch == 4'(TACH_NUM - 1)) ? 4'd0 : cur_ch + 4'd1;
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) tach_status <= '0;
        else          tach_status <= (tach_status & ~clr_bits) | (store_en ? ch_onehot : '0);
    end

    // A timed-out channel records a duration of 0.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < TACH_NUM; i++) dur[i] <= 16'd0;
        end else begin
            for (int i = 0; i < TACH_NUM; i++) begin
                if ((store_en || timeout_en) && ch_onehot[i])
                    dur[i] <= store_en ? eng.eng_dur : 16'd0;
            end
        end
    end

    // Registered so the engine input is 0 while in reset; the settle window
    // absorbs the extra cycle after a channel switch.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) eng.eng_tachin <= 1'b0;
        else          eng.eng_tachin <= |(TACHIN & ch_onehot);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) tach_irq <= 1'b0;
        else          tach_irq <= |(tach_status & irq_mask);
    end

    always_comb begin
        rd_dur = 16'd0;
        for (int i = 0; i < TACH_NUM; i++) begin
            if (rd_ch == 4'(i)) rd_dur = dur[i];
        end
    end

endmodule
